// File: rtl/systolic_sequencer.sv
// systolic_sequencer: latches 2x2 operands and drives skewed feeds/controls into a 2x2 systolic MAC array
module systolic_sequencer #(
  parameter int OP_WIDTH     = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  acc_keep,
  input  logic [4*OP_WIDTH-1:0] a_matrix,
  input  logic [4*OP_WIDTH-1:0] b_matrix,
  output logic [2*OP_WIDTH-1:0] new_a_column,
  output logic [2*OP_WIDTH-1:0] new_b_row,
  output logic                  mac_clear,
  output logic                  mac_en,
  output logic                  busy,
  output logic                  done
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [1:0] t, t_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [4*OP_WIDTH-1:0] a_lat, b_lat, a_src, b_src;
  logic [2*OP_WIDTH-1:0] a_col_n, b_row_n;
  // next state, step and drain counters
  always_comb begin
    state_n = state;
    t_n     = t;
    dcnt_n  = dcnt;
    case (state)
      IDLE: begin
        state_n = start ? (acc_keep ? FEED : CLEAR) : IDLE;
        t_n     = '0;
      end
      CLEAR: begin
        state_n = FEED;
        t_n     = '0;
      end
      FEED: begin
        state_n = t == 2'd2 ? DRAIN : FEED;
        t_n     = t == 2'd2 ? 2'd0 : t + 2'd1;
        dcnt_n  = '0;
      end
      DRAIN: begin
        state_n = dcnt == DW'(DRAIN_CYCLES - 1) ? DONE : DRAIN;
        dcnt_n  = dcnt == DW'(DRAIN_CYCLES - 1) ? '0 : dcnt + 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // skewed feed values for the coming cycle; the incoming matrices are used directly on the start edge
  always_comb begin
    a_src   = state == IDLE ? a_matrix : a_lat;
    b_src   = state == IDLE ? b_matrix : b_lat;
    a_col_n = '0;
    b_row_n = '0;
    for (int i = 0; i < 2; i++) begin
      if (state_n == FEED && int'(t_n) - i >= 0 && int'(t_n) - i <= 1) begin
        a_col_n[i*OP_WIDTH +: OP_WIDTH] = a_src[(2*i + int'(t_n) - i)*OP_WIDTH +: OP_WIDTH];
        b_row_n[i*OP_WIDTH +: OP_WIDTH] = b_src[(2*(int'(t_n) - i) + i)*OP_WIDTH +: OP_WIDTH];
      end
    end
  end
  // state, operand latches and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      t            <= '0;
      dcnt         <= '0;
      a_lat        <= '0;
      b_lat        <= '0;
      new_a_column <= '0;
      new_b_row    <= '0;
      mac_clear    <= 1'b0;
      mac_en       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      t            <= t_n;
      dcnt         <= dcnt_n;
      a_lat        <= state == IDLE && start ? a_matrix : a_lat;
      b_lat        <= state == IDLE && start ? b_matrix : b_lat;
      new_a_column <= a_col_n;
      new_b_row    <= b_row_n;
      mac_clear    <= state_n == CLEAR;
      mac_en       <= state_n == FEED || state_n == DRAIN;
      busy         <= state_n == CLEAR || state_n == FEED || state_n == DRAIN;
      done         <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: schedule model plus behavioural systolic MAC grid checking systolic_sequencer
module tb_systolic_sequencer;
  localparam int D = 3;
  logic clk = 1'b0;
  logic reset, start, acc_keep;
  logic [31:0] a_matrix, b_matrix;
  logic [15:0] new_a_column, new_b_row;
  logic mac_clear, mac_en, busy, done;
  int n_chk = 0, n_pass = 0;
  bit armed = 0;
  bit m_act = 0;
  bit m_keep = 0;
  int m_k = 0;
  logic [31:0] m_a, m_b;
  int c_acc [2][2] = '{'{0, 0}, '{0, 0}};
  logic [15:0] pa = '0, pb = '0;
  logic [15:0] cap_a [64], cap_b [64];
  logic cap_c [64];
  int n, clr_cnt, dn;

  systolic_sequencer #(.OP_WIDTH(8), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .start(start), .acc_keep(acc_keep),
    .a_matrix(a_matrix), .b_matrix(b_matrix),
    .new_a_column(new_a_column), .new_b_row(new_b_row),
    .mac_clear(mac_clear), .mac_en(mac_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(int m00, int m01, int m10, int m11);
    return {8'(m11), 8'(m10), 8'(m01), 8'(m00)};
  endfunction

  function automatic logic [7:0] el(logic [31:0] v, int r, int c);
    return v[(2*r + c)*8 +: 8];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_c(int e00, int e01, int e10, int e11);
    chk("c00", c_acc[0][0], e00);
    chk("c01", c_acc[0][1], e01);
    chk("c10", c_acc[1][0], e10);
    chk("c11", c_acc[1][1], e11);
  endtask

  // operation timeline: phase s counts cycles since the accepted start, shifted by one when clear is skipped
  always @(posedge clk) begin
    if (reset) m_act <= 0;
    else if (m_act) begin
      m_k <= m_k + 1;
      if (m_k + 1 + int'(m_keep) > 5 + D) m_act <= 0;
    end else if (start) begin
      m_act  <= 1;
      m_k    <= 1;
      m_keep <= acc_keep;
      m_a    <= a_matrix;
      m_b    <= b_matrix;
    end
  end

  // expected outputs from the schedule, compared every cycle
  always @(negedge clk) begin
    logic [15:0] ea, eb;
    logic eclr, een, ebusy, edone;
    int s, tt;
    ea = '0; eb = '0; eclr = 0; een = 0; ebusy = 0; edone = 0;
    s = m_k + int'(m_keep);
    if (m_act) begin
      if (s == 1) begin
        eclr = 1; ebusy = 1;
      end else if (s >= 2 && s <= 4) begin
        tt = s - 2;
        for (int i = 0; i < 2; i++) begin
          if (tt - i >= 0 && tt - i <= 1) begin
            ea[i*8 +: 8] = el(m_a, i, tt - i);
            eb[i*8 +: 8] = el(m_b, tt - i, i);
          end
        end
        een = 1; ebusy = 1;
      end else if (s >= 5 && s <= 4 + D) begin
        een = 1; ebusy = 1;
      end else if (s == 5 + D) edone = 1;
    end
    if (armed) begin
      chk("new_a_column", new_a_column, ea);
      chk("new_b_row", new_b_row, eb);
      chk("mac_clear", mac_clear, eclr);
      chk("mac_en", mac_en, een);
      chk("busy", busy, ebusy);
      chk("done", done, edone);
    end
  end

  // behavioural 2x2 systolic grid: PE(i,j) sees row i delayed j cycles and column j delayed i cycles
  always @(negedge clk) begin
    if (mac_clear === 1'b1) c_acc = '{'{0, 0}, '{0, 0}};
    if (mac_en === 1'b1)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          c_acc[i][j] += int'(j == 0 ? new_a_column[i*8 +: 8] : pa[i*8 +: 8]) *
                         int'(i == 0 ? new_b_row[j*8 +: 8] : pb[j*8 +: 8]);
    pa = new_a_column;
    pb = new_b_row;
  end

  task automatic run_op(logic [31:0] a, logic [31:0] b, logic k);
    @(negedge clk);
    start = 1; acc_keep = k; a_matrix = a; b_matrix = b;
    @(negedge clk);
    start = 0;
    n = 1; clr_cnt = 0;
    cap_a[1] = new_a_column; cap_b[1] = new_b_row; cap_c[1] = mac_clear;
    clr_cnt += int'(mac_clear);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      cap_a[n] = new_a_column; cap_b[n] = new_b_row; cap_c[n] = mac_clear;
      clr_cnt += int'(mac_clear);
    end
  endtask

  initial begin
    reset = 1; start = 0; acc_keep = 0; a_matrix = '0; b_matrix = '0;
    @(posedge clk);
    #1 armed = 1;
    repeat (5) begin
      @(negedge clk);
      start = 1;
    end
    @(negedge clk);
    start = 0; reset = 0;
    chk("reset_busy", busy, 0);
    chk("reset_a", new_a_column, 0);

    run_op(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 0);
    chk("op1_done_cycle", n, 8);
    chk("op1_clear_c1", cap_c[1], 1);
    chk("op1_clear_count", clr_cnt, 1);
    chk("op1_a_t0", cap_a[2], 16'h0001);
    chk("op1_b_t0", cap_b[2], 16'h0005);
    chk("op1_a_t1", cap_a[3], 16'h0302);
    chk("op1_b_t1", cap_b[3], 16'h0607);
    chk("op1_a_t2", cap_a[4], 16'h0400);
    chk("op1_b_t2", cap_b[4], 16'h0800);
    chk_c(19, 22, 43, 50);

    run_op(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1);
    chk("keep_done_cycle", n, 7);
    chk("keep_clear_count", clr_cnt, 0);
    chk("keep_a_t0", cap_a[1], 16'h0001);
    chk_c(38, 44, 86, 100);

    @(negedge clk);
    start = 1; acc_keep = 0; a_matrix = pk(1, 2, 3, 4); b_matrix = pk(5, 6, 7, 8);
    n = 0; dn = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      a_matrix = $urandom;
      dn += int'(done);
    end
    chk("hammer_done_cycle", n, 8);
    chk("hammer_done_count", dn, 1);
    chk_c(19, 22, 43, 50);
    @(negedge clk);
    chk("hammer_idle_after_done", busy, 0);
    @(negedge clk);
    start = 0;
    chk("hammer_restart_busy", busy, 1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hammer_restart_done", n, 7);

    @(negedge clk);
    start = 1; acc_keep = 0; a_matrix = pk(1, 2, 3, 4); b_matrix = pk(5, 6, 7, 8);
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_mac_en", mac_en, 0);
    chk("abort_a", new_a_column, 0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("abort_no_done", dn, 0);
    run_op(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 0);
    chk("abort_rerun_done", n, 8);
    chk_c(19, 22, 43, 50);

    run_op(pk(255, 255, 255, 255), pk(255, 255, 255, 255), 0);
    chk("ff_a_t0", cap_a[2], 16'h00FF);
    chk("ff_a_t1", cap_a[3], 16'hFFFF);
    chk("ff_b_t2", cap_b[4], 16'hFF00);
    chk_c(130050, 130050, 130050, 130050);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
